ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 8'hED (set LEDs) or 8'hFF (reset). It sits beside the PS/2 scan-code receiver on the same `ps2_kbd_clk`/`ps2_kbd_data` pins and drives them through open-drain enables. `busy` lets the receiver be gated while a transmission owns the bus.

---
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// through open-drain enables on the shared PS/2 clock/data pins.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3200,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_AB = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic [3:0]    hist_q;
    logic          filt_q, filt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;
    logic          cur_q, cur_d;
    logic          ack_ok_q, ack_ok_d;

    // Synchronize pins and keep the 4-sample clock history plus filtered clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            hist_q    <= '1;
            filt_q    <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
            hist_q    <= {hist_q[2:0], clk_s2_q};
            filt_q    <= filt_d;
        end
    end

    // Filtered clock follows the history only when all four samples agree.
    always_comb begin
        filt_d = filt_q;
        if (hist_q == 4'b1111) begin
            filt_d = 1'b1;
        end else if (hist_q == 4'b0000) begin
            filt_d = 1'b0;
        end
        fall = filt_q & ~filt_d;
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '1;
            cur_q    <= 1'b1;
            ack_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            cur_q    <= cur_d;
            ack_ok_q <= ack_ok_d;
        end
    end

    // Next-state logic; done/error pulse in the last busy cycle before IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        frame_d  = frame_q;
        cur_d    = cur_q;
        ack_ok_d = ack_ok_q;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    bit_d    = '0;
                    cur_d    = 1'b0;
                    ack_ok_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (fall) begin
                    cnt_d   = '0;
                    cur_d   = frame_q[0];
                    frame_d = {1'b1, frame_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (cnt_q == TMO) begin
                    error   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d    = '0;
                    ack_ok_d = ~data_s2_q;
                    state_d  = S_WAIT_IDLE;
                end else if (cnt_q == TMO) begin
                    error   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q && data_s2_q) begin
                    done    = ack_ok_q;
                    error   = ~ack_ok_q;
                    state_d = S_IDLE;
                end else if (cnt_q == TMO) begin
                    error   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin enables and handshake decoded from the registered state.
    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
        ps2_data_oe = (state_q == S_REQ) || ((state_q == S_SEND) && !cur_q);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;

    localparam logic [1:0] RES_DONE = 2'b10;
    localparam logic [1:0] RES_ERR  = 2'b01;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin, ps2_data_pin;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_cyc = 0;
    int res_count = 0;
    int t_send = 0;
    int dev_mode = 0;     // 0 ack, 1 nack, 2 silent, 3 unchecked (reset test)
    int dev_falls = 0;
    logic dev_abort = 1'b0;
    logic dev_active = 1'b0;

    logic       exp_bits[$];
    logic [1:0] exp_res[$];

    assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_pin = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .REQ_CYCLES(4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .error(error),
        .ps2_clk_i(ps2_clk_pin),
        .ps2_data_i(ps2_data_pin),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result monitor: every done/error pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (done || error) begin
            res_cyc = cyc;
            res_count++;
            if (exp_res.size() == 0) check("unexpected_pulse", 32'({done, error}), 32'd0);
            else check("result", 32'({done, error}), 32'(exp_res.pop_front()));
        end
    end

    // Device model: clocks 10 bits sampling on rising edges, then the ack clock.
    task automatic half();
        repeat (20) @(negedge clk);
    endtask

    task automatic run_frame();
        logic s;
        dev_falls = 0;
        half();
        for (int k = 0; k < 10; k++) begin
            if (dev_abort) break;
            dev_clk = 1'b0;
            dev_falls++;
            half();
            dev_clk = 1'b1;
            if (!dev_abort && dev_mode < 2) begin
                s = ps2_data_pin;
                if (exp_bits.size() != 0) check("frame_bit", 32'(s), 32'(exp_bits.pop_front()));
                else check("frame_bit_queue", 32'(exp_bits.size()), 32'd1);
            end
            half();
        end
        if (!dev_abort) begin
            dev_data = (dev_mode == 1) ? 1'b1 : 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            half();
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (reset_n && busy && !ps2_clk_oe && ps2_data_oe) begin
                dev_active = 1'b1;
                if (dev_mode == 2) begin
                    while (busy) @(negedge clk);
                end else begin
                    run_frame();
                end
                dev_active = 1'b0;
            end
        end
    end

    // Present a byte and hold it until accepted; push expectations at acceptance.
    task automatic issue(input logic [7:0] d, input logic [9:0] frame, input int mode);
        dev_mode = mode;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !tx_ready; i++) @(negedge clk);
        check("ready_wait", 32'(tx_ready), 32'd1);
        if (mode < 2) begin
            for (int b = 0; b < 10; b++) exp_bits.push_back(frame[b]);
        end
        if (mode == 0) exp_res.push_back(RES_DONE);
        else if (mode != 3) exp_res.push_back(RES_ERR);
    endtask

    // Called one cycle after acceptance: measure INHIBIT+REQ and the REQ window.
    task automatic after_accept();
        int n = 0;
        int dn = 0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_not_ready", 32'(tx_ready), 32'd0);
        while (ps2_clk_oe && n < 1000) begin
            n++;
            if (ps2_data_oe) dn++;
            @(negedge clk);
        end
        check("clk_oe_len", 32'(n), 32'd12);
        check("req_len", 32'(dn), 32'd4);
        t_send = cyc;
    endtask

    task automatic wait_result(input int n0);
        for (int i = 0; i < 3000 && res_count <= n0; i++) @(negedge clk);
        check("result_seen", 32'(res_count > n0), 32'd1);
    endtask

    task automatic wait_dev_idle();
        for (int i = 0; i < 3000 && dev_active; i++) @(negedge clk);
        check("dev_idle", 32'(dev_active), 32'd0);
    endtask

    task automatic run(input logic [7:0] d, input logic [9:0] frame, input int mode);
        int n0 = res_count;
        issue(d, frame, mode);
        @(negedge clk);
        tx_valid = 1'b0;
        after_accept();
        wait_result(n0);
        if (mode == 2) begin
            check("timeout_latency", 32'(res_cyc - t_send), 32'd200);
            @(negedge clk);
            check("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
        end else begin
            @(negedge clk);
        end
        check("ready_after", 32'(tx_ready), 32'd1);
        wait_dev_idle();
    endtask

    initial begin : stim
        int n0;
        int acc_cyc;
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);

        // Frames are {stop, odd parity, data}, hand-computed.
        run(8'hED, 10'h3ED, 0);
        run(8'h07, 10'h207, 0);
        run(8'h00, 10'h300, 0);
        run(8'hFF, 10'h3FF, 1);
        run(8'h5A, 10'h000, 2);

        // Reset after fall 5 while bit 4 (a zero) is driving data low.
        n0 = res_count;
        issue(8'h0F, 10'h000, 3);
        @(negedge clk);
        tx_valid = 1'b0;
        after_accept();
        for (int i = 0; i < 3000 && dev_falls < 5; i++) @(negedge clk);
        check("fall5_seen", 32'(dev_falls >= 5), 32'd1);
        repeat (12) @(negedge clk);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        reset_n   = 1'b0;
        dev_abort = 1'b1;
        #1;
        check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_dev_idle();
        dev_abort = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(tx_ready), 32'd1);
        check("post_rst_no_pulse", 32'(res_count - n0), 32'd0);

        // Back-to-back: second byte held valid during the first transfer.
        n0 = res_count;
        issue(8'h01, 10'h201, 0);
        @(negedge clk);
        tx_data = 8'hA5;
        after_accept();
        issue(8'hA5, 10'h3A5, 0);
        acc_cyc = cyc;
        check("b2b_first_done", 32'(res_count - n0), 32'd1);
        check("b2b_gap", 32'(acc_cyc - res_cyc), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        after_accept();
        wait_result(n0 + 1);
        @(negedge clk);
        check("b2b_ready_after", 32'(tx_ready), 32'd1);
        wait_dev_idle();

        repeat (20) @(negedge clk);
        check("bits_drained", 32'(exp_bits.size()), 32'd0);
        check("results_drained", 32'(exp_res.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
